// File: rtl/rc4_decrypt.sv
// RC4 keystream generator (PRGA): swaps through the shuffled S array, XORs the keystream
// with the ciphertext ROM, writes plaintext RAM and tracks whether the text is lowercase/space.
module rc4_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] dec_address,
  output logic [7:0]        dec_data,
  output logic              dec_wren,
  output logic              finish,
  output logic              msg_ok
);

  typedef enum logic [4:0] {
    IDLE,
    INC_I,
    RD_SI,
    WAIT_SI,
    LATCH_SI,
    RD_SJ,
    WAIT_SJ,
    LATCH_SJ,
    WR_I,
    WR_J,
    WR_SETTLE,
    RD_F,
    WAIT_F,
    LATCH_F,
    WR_DEC,
    NEXT,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  state_t            state, state_next;
  logic [7:0]        i, i_next;
  logic [7:0]        j, j_next;
  logic [ADDR_W-1:0] k, k_next;
  logic [7:0]        si, si_next;
  logic [7:0]        sj, sj_next;

  logic [7:0]        s_address_next;
  logic [7:0]        s_data_next;
  logic              s_wren_next;
  logic [ADDR_W-1:0] rom_address_next;
  logic [ADDR_W-1:0] dec_address_next;
  logic [7:0]        dec_data_next;
  logic              dec_wren_next;
  logic              finish_next;
  logic              msg_ok_next;

  // State, index registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i           <= 8'd0;
      j           <= 8'd0;
      k           <= '0;
      si          <= 8'd0;
      sj          <= 8'd0;
      s_address   <= 8'd0;
      s_data      <= 8'd0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      dec_address <= '0;
      dec_data    <= 8'd0;
      dec_wren    <= 1'b0;
      finish      <= 1'b0;
      msg_ok      <= 1'b1;
    end else begin
      state       <= state_next;
      i           <= i_next;
      j           <= j_next;
      k           <= k_next;
      si          <= si_next;
      sj          <= sj_next;
      s_address   <= s_address_next;
      s_data      <= s_data_next;
      s_wren      <= s_wren_next;
      rom_address <= rom_address_next;
      dec_address <= dec_address_next;
      dec_data    <= dec_data_next;
      dec_wren    <= dec_wren_next;
      finish      <= finish_next;
      msg_ok      <= msg_ok_next;
    end
  end

  // Next state; outputs are computed for the state being entered so they hold through it.
  always_comb begin
    state_next       = state;
    i_next           = i;
    j_next           = j;
    k_next           = k;
    si_next          = si;
    sj_next          = sj;
    s_address_next   = s_address;
    s_data_next      = s_data;
    s_wren_next      = 1'b0;
    rom_address_next = rom_address;
    dec_address_next = dec_address;
    dec_data_next    = dec_data;
    dec_wren_next    = 1'b0;
    finish_next      = finish;
    msg_ok_next      = msg_ok;

    case (state)
      IDLE: begin
        if (start) begin
          i_next      = 8'd0;
          j_next      = 8'd0;
          k_next      = '0;
          msg_ok_next = 1'b1;
          state_next  = INC_I;
        end else begin
          state_next  = IDLE;
        end
      end
      INC_I: begin
        i_next         = i + 8'd1;
        s_address_next = i + 8'd1;
        state_next     = RD_SI;
      end
      RD_SI:   state_next = WAIT_SI;
      WAIT_SI: state_next = LATCH_SI;
      LATCH_SI: begin
        si_next        = s_q;
        j_next         = j + s_q;
        s_address_next = j + s_q;
        state_next     = RD_SJ;
      end
      RD_SJ:   state_next = WAIT_SJ;
      WAIT_SJ: state_next = LATCH_SJ;
      LATCH_SJ: begin
        sj_next        = s_q;
        s_address_next = i;
        s_data_next    = s_q;
        s_wren_next    = 1'b1;
        state_next     = WR_I;
      end
      WR_I: begin
        s_address_next = j;
        s_data_next    = si;
        s_wren_next    = 1'b1;
        state_next     = WR_J;
      end
      // One bubble lets both swap writes land before the keystream read address is presented.
      WR_J:      state_next = WR_SETTLE;
      WR_SETTLE: begin
        s_address_next   = si + sj;
        rom_address_next = k;
        state_next       = RD_F;
      end
      RD_F:   state_next = WAIT_F;
      WAIT_F: state_next = LATCH_F;
      LATCH_F: begin
        dec_address_next = k;
        dec_data_next    = s_q ^ rom_q;
        dec_wren_next    = 1'b1;
        state_next       = WR_DEC;
      end
      WR_DEC: begin
        if (!is_text(dec_data)) begin
          msg_ok_next = 1'b0;
        end else begin
          msg_ok_next = msg_ok;
        end
        state_next = NEXT;
      end
      NEXT: begin
        if (k == K_LAST) begin
          finish_next = 1'b1;
          state_next  = DONE;
        end else begin
          k_next      = k + ADDR_W'(1);
          state_next  = INC_I;
        end
      end
      DONE: begin
        finish_next = 1'b1;
        state_next  = DONE;
      end
      default: state_next = IDLE;
    endcase

    // Dropping start aborts from any state, including mid-strobe.
    if (!start) begin
      state_next       = IDLE;
      i_next           = 8'd0;
      j_next           = 8'd0;
      k_next           = '0;
      si_next          = 8'd0;
      sj_next          = 8'd0;
      s_address_next   = 8'd0;
      s_data_next      = 8'd0;
      s_wren_next      = 1'b0;
      rom_address_next = '0;
      dec_address_next = '0;
      dec_data_next    = 8'd0;
      dec_wren_next    = 1'b0;
      finish_next      = 1'b0;
      msg_ok_next      = 1'b1;
    end else begin
      state_next       = state_next;
    end
  end

endmodule
